// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider handshake: operands, start/annul, and the HI/LO result path.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dvd_q;    // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0]   dvs_q;    // divisor magnitude
  logic [WIDTH-1:0]   rem_q;    // partial remainder
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   mag_a_c;
  logic [WIDTH-1:0]   mag_b_c;
  logic [WIDTH:0]     trial_c;
  logic [WIDTH:0]     diff_c;
  logic               borrow_c;
  logic [WIDTH-1:0]   quot_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;
  logic               early_c;

  assign mag_a_c = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag_b_c = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Trial subtract on the shifted remainder; the extra top bit catches the borrow.
  assign trial_c  = {rem_q, dvd_q[WIDTH-1]};
  assign diff_c   = trial_c - {1'b0, dvs_q};
  assign borrow_c = diff_c[WIDTH];

  assign quot_fix_c = neg_quot_q ? -dvd_q : dvd_q;
  assign rem_fix_c  = neg_rem_q  ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
  assign early_c = (mag_a_c < mag_b_c);
`else
  assign early_c = 1'b0;
`endif

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (bus.start_i && !bus.annul_i) begin
            dvd_q      <= mag_a_c;
            dvs_q      <= mag_b_c;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_q  <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            if (bus.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else if (early_c) begin
              // Quotient is zero, remainder is the untouched dividend.
              rem_q   <= bus.opdata1_i;
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
            end
          end
        end
        BYZERO: begin
          if (bus.annul_i) begin
            state_q <= FREE;
          end else begin
            result_q <= {rem_q, {WIDTH{1'b0}}};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            state_q <= FREE;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            result_q <= {rem_fix_c, quot_fix_c};
            ready_q  <= 1'b1;
            state_q  <= END;
          end else begin
            rem_q <= borrow_c ? trial_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], ~borrow_c};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        END: begin
          if (!bus.start_i || bus.annul_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= FREE;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: results, latency, stall, annul, reset.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(32)) bus ();
  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and returns the edge index (E0 = accept) where ready_o was first seen.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output logic stall_ok);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    stall_ok = (bus.stallreq_o === 1'b1);
    lat = -1;
    res = 'x;
    for (int e = 0; e < 60 && lat < 0; e++) begin
      step();
      if (bus.ready_o === 1'b1) begin
        lat = e;
        res = bus.result_o;
        if (bus.stallreq_o !== 1'b0) stall_ok = 1'b0;
      end else if (bus.stallreq_o !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    step(); step();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stallreq_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_divu();
    int lat; logic [63:0] res; logic st;
    run_div(1'b0, 32'd100, 32'd7, lat, res, st);
    checks++; if (lat !== 33) begin failures++; $display("FAIL divu_lat got=%0d exp=33", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_res got=%h exp=%h", res, {32'd2, 32'd14}); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL divu_stall got=%b exp=1", st); end
    bus.start_i = 1'b0;
    step();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL divu_drop_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL divu_drop_result got=%h exp=0", bus.result_o); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; logic st;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, lat, res, st);
    checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_m7_2 got=%h exp=%h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    bus.start_i = 1'b0; step();
    run_div(1'b1, 32'h7, 32'hFFFF_FFFE, lat, res, st);
    checks++; if (res !== {32'h1, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_7_m2 got=%h exp=%h", res, {32'h1, 32'hFFFF_FFFD}); end
    bus.start_i = 1'b0; step();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, st);
    checks++; if (res !== {32'h0, 32'h8000_0000}) begin failures++; $display("FAIL div_overflow got=%h exp=%h", res, {32'h0, 32'h8000_0000}); end
    bus.start_i = 1'b0; step();
    run_div(1'b0, 32'hFFFF_FFFF, 32'h1, lat, res, st);
    checks++; if (res !== {32'h0, 32'hFFFF_FFFF}) begin failures++; $display("FAIL divu_max got=%h exp=%h", res, {32'h0, 32'hFFFF_FFFF}); end
    bus.start_i = 1'b0; step();
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, res, st);
    checks++; if (res !== {32'hFFFF_FFFE, 32'hE}) begin failures++; $display("FAIL div_m100_m7 got=%h exp=%h", res, {32'hFFFF_FFFE, 32'hE}); end
    bus.start_i = 1'b0; step();
  endtask

  task automatic test_byzero();
    int lat; logic [63:0] res; logic st;
    run_div(1'b0, 32'd5, 32'd0, lat, res, st);
    checks++; if (lat !== 1) begin failures++; $display("FAIL byzero_lat got=%0d exp=1", lat); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL byzero_res got=%h exp=0", res); end
    bus.start_i = 1'b0;
    step();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL byzero_drop got=%b exp=0", bus.ready_o); end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; logic st; logic rose;
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1; bus.annul_i = 1'b0;
    rose = 1'b0;
    for (int e = 0; e < 10; e++) begin step(); if (bus.ready_o !== 1'b0) rose = 1'b1; end
    bus.annul_i = 1'b1;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL annul_stall got=%b exp=0", bus.stallreq_o); end
    step();
    bus.annul_i = 1'b0; bus.start_i = 1'b0;
    for (int e = 0; e < 40; e++) begin step(); if (bus.ready_o !== 1'b0) rose = 1'b1; end
    checks++; if (rose !== 1'b0) begin failures++; $display("FAIL annul_no_ready got=%b exp=0", rose); end
    run_div(1'b0, 32'd9, 32'd3, lat, res, st);
    checks++; if (lat !== 33) begin failures++; $display("FAIL after_annul_lat got=%0d exp=33", lat); end
    checks++; if (res !== {32'd0, 32'd3}) begin failures++; $display("FAIL after_annul_res got=%h exp=%h", res, {32'd0, 32'd3}); end
    bus.start_i = 1'b0; step();
  endtask

  task automatic test_start_drop();
    logic [63:0] seen; logic early_rdy;
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1; bus.annul_i = 1'b0;
    early_rdy = 1'b0;
    for (int e = 0; e <= 4; e++) step();
    bus.start_i = 1'b0;
    bus.opdata1_i = 32'hDEAD_BEEF; bus.opdata2_i = 32'd3;
    for (int e = 5; e <= 32; e++) begin step(); if (bus.ready_o !== 1'b0) early_rdy = 1'b1; end
    checks++; if (early_rdy !== 1'b0) begin failures++; $display("FAIL drop_early_ready got=%b exp=0", early_rdy); end
    step();
    seen = bus.result_o;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL drop_ready_e33 got=%b exp=1", bus.ready_o); end
    checks++; if (seen !== {32'd2, 32'd14}) begin failures++; $display("FAIL drop_result got=%h exp=%h", seen, {32'd2, 32'd14}); end
    step();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL drop_ready_e34 got=%b exp=0", bus.ready_o); end
  endtask

  task automatic test_rst_mid();
    int lat; logic [63:0] res; logic st;
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1; bus.annul_i = 1'b0;
    for (int e = 0; e <= 4; e++) step();
    rst = 1'b1;
    step();
    checks++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin failures++; $display("FAIL rst_mid got=%b/%h exp=0/0", bus.ready_o, bus.result_o); end
    rst = 1'b0; bus.start_i = 1'b0;
    step();
    run_div(1'b0, 32'd20, 32'd6, lat, res, st);
    checks++; if (res !== {32'd2, 32'd3}) begin failures++; $display("FAIL rst_pre_end got=%h exp=%h", res, {32'd2, 32'd3}); end
    rst = 1'b1;
    step();
    checks++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin failures++; $display("FAIL rst_in_end got=%b/%h exp=0/0", bus.ready_o, bus.result_o); end
    rst = 1'b0; bus.start_i = 1'b0;
    step();
  endtask

  task automatic test_early_out();
    int lat; logic [63:0] res; logic st;
    run_div(1'b0, 32'd3, 32'd10, lat, res, st);
    checks++; if (lat !== EARLY_LAT) begin failures++; $display("FAIL early_lat got=%0d exp=%0d", lat, EARLY_LAT); end
    checks++; if (res !== {32'd3, 32'd0}) begin failures++; $display("FAIL early_res got=%h exp=%h", res, {32'd3, 32'd0}); end
    bus.start_i = 1'b0; step();
    run_div(1'b1, 32'hFFFF_FFFD, 32'd10, lat, res, st);
    checks++; if (res !== {32'hFFFF_FFFD, 32'd0}) begin failures++; $display("FAIL early_neg_res got=%h exp=%h", res, {32'hFFFF_FFFD, 32'd0}); end
    bus.start_i = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_byzero();
    test_annul();
    test_start_drop();
    test_rst_mid();
    test_early_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
